// File: rtl/pacote_matriz.sv
// Shared definitions for the matrix-multiply sequencer: dimensions, size codes,
// FSM state encoding and the packed-element offset helper.
package pacote_matriz;

  localparam int MAT_DIM  = 5;
  localparam int ELEM_W   = 8;
  localparam int ACC_W    = 18;
  localparam int NUM_ELEM = MAT_DIM * MAT_DIM;
  localparam int BUS_W    = NUM_ELEM * ELEM_W;

  localparam logic [1:0] SIZE_2X2 = 2'b00;
  localparam logic [1:0] SIZE_3X3 = 2'b01;
  localparam logic [1:0] SIZE_4X4 = 2'b10;
  localparam logic [1:0] SIZE_5X5 = 2'b11;

  // Representable range of one stored result element, at accumulator width.
  localparam logic signed [ACC_W-1:0] ELEM_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] ELEM_MIN = ACC_W'(-128);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAC,
    ST_WRITE,
    ST_DONE
  } estado_t;

  function automatic int unsigned elem_off(input logic [2:0] i, input logic [2:0] j);
    return (int'(i) * MAT_DIM + int'(j)) * ELEM_W;
  endfunction

endpackage

// File: rtl/mac_elemento.sv
// Registered signed 8x8 multiply-accumulate; clear has priority over enable.
module mac_elemento
  import pacote_matriz::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_i,
  input  logic                     en_i,
  input  logic signed [ELEM_W-1:0] op_a_i,
  input  logic signed [ELEM_W-1:0] op_b_i,
  output logic signed [ACC_W-1:0]  acc_o
);

  logic signed [2*ELEM_W-1:0] produto;
  logic signed [ACC_W-1:0]    acc_q, acc_d;

  assign produto = op_a_i * op_b_i;

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + {{(ACC_W - 2*ELEM_W){produto[2*ELEM_W-1]}}, produto};
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/controle_multiplicacao.sv
// Multi-cycle matrix-multiply sequencer (one MAC per clock, up to 5x5).
// Define MULT_SATURATE_EN to clamp stored elements instead of truncating them.
module controle_multiplicacao
  import pacote_matriz::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BUS_W-1:0] matrix_a,
  input  logic [BUS_W-1:0] matrix_b,
  input  logic [1:0]       matrix_size,
  output logic             busy,
  output logic             done,
  output logic [BUS_W-1:0] result_out,
  output logic             overflow_flag
);

  estado_t                 state_q, state_d;
  logic [BUS_W-1:0]        a_q, a_d, b_q, b_d, res_q, res_d, a_rs, b_rs;
  logic [2:0]              n_q, n_d, i_q, i_d, j_q, j_d, k_q, k_d, n_in;
  logic                    ovf_q, ovf_d, acc_ovf;
  logic signed [ACC_W-1:0] acc;
  logic signed [ELEM_W-1:0] op_a, op_b, stored;

  assign n_in = {1'b0, matrix_size} + 3'd2;

  // Re-stride incoming n x n packing onto the fixed 5x5 grid, zero-filling the rest.
  always_comb begin
    a_rs = '0;
    b_rs = '0;
    for (int r = 0; r < MAT_DIM; r++) begin
      for (int c = 0; c < MAT_DIM; c++) begin
        if (r < int'(n_in) && c < int'(n_in)) begin
          a_rs[(r*MAT_DIM + c)*ELEM_W +: ELEM_W] = matrix_a[(r*int'(n_in) + c)*ELEM_W +: ELEM_W];
          b_rs[(r*MAT_DIM + c)*ELEM_W +: ELEM_W] = matrix_b[(r*int'(n_in) + c)*ELEM_W +: ELEM_W];
        end
      end
    end
  end

  assign op_a    = a_q[elem_off(i_q, k_q) +: ELEM_W];
  assign op_b    = b_q[elem_off(k_q, j_q) +: ELEM_W];
  assign acc_ovf = (acc > ELEM_MAX) || (acc < ELEM_MIN);

`ifdef MULT_SATURATE_EN
  assign stored = (acc > ELEM_MAX) ? 8'sh7F :
                  (acc < ELEM_MIN) ? 8'sh80 : acc[ELEM_W-1:0];
`else
  assign stored = acc[ELEM_W-1:0];
`endif

  mac_elemento u_mac (
    .clk     (clk),
    .reset   (reset),
    .clear_i ((state_q == ST_LOAD) || (state_q == ST_WRITE)),
    .en_i    (state_q == ST_MAC),
    .op_a_i  (op_a),
    .op_b_i  (op_b),
    .acc_o   (acc)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          a_d     = a_rs;
          b_d     = b_rs;
          n_d     = n_in;
        end
      end
      ST_LOAD: begin
        res_d   = '0;
        ovf_d   = 1'b0;
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
        state_d = ST_MAC;
      end
      ST_MAC: begin
        if (k_q == n_q - 3'd1) begin
          k_d     = '0;
          state_d = ST_WRITE;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      ST_WRITE: begin
        res_d[elem_off(i_q, j_q) +: ELEM_W] = stored;
        ovf_d   = ovf_q | acc_ovf;
        k_d     = '0;
        state_d = ST_MAC;
        if (j_q == n_q - 3'd1) begin
          j_d = '0;
          if (i_q == n_q - 3'd1) state_d = ST_DONE;
          else                   i_d     = i_q + 3'd1;
        end else begin
          j_d = j_q + 3'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign result_out    = res_q;
  assign overflow_flag = ovf_q;

endmodule

// File: doc/controle_multiplicacao.md
# controle_multiplicacao

Sequencing controller for the coprocessor's matrix-multiply datapath. It latches two packed signed 8-bit matrices (2x2 to 5x5) on a start handshake and computes the product with a single shared multiply-accumulate unit, one MAC per clock. It then raises a one-cycle `done` with the packed 5x5 result and a sticky overflow flag. It replaces the fully combinational 125-multiplier array with an area-cheap multi-cycle schedule on the coprocessor's operation bus.

## Interface
- `MAT_DIM`, 5: maximum matrix dimension (result stride).
- `ELEM_W`, 8: element width, signed two's complement.
- `ACC_W`, 18: accumulator width (holds 5·(−128)·(−128)=81920 exactly).
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; forces IDLE and clears all outputs.
- `start`  in  1  request; sampled only in IDLE.
- `matrix_a`, `matrix_b`  in  200  packed row-major n×n operands, element e at bits [e*8+:8].
- `matrix_size`  in  2  00:2x2, 01:3x3, 10:4x4, 11:5x5; sampled with `start`.
- `busy`  out  1  high from LOAD through DONE inclusive.
- `done`  out  1  one-cycle pulse; `result_out`/`overflow_flag` valid.
- `result_out`  out  200  5x5 result, element (i,j) at bits [(i*5+j)*8+:8].
- `overflow_flag`  out  1  any element sum outside [−128,127].

## Operation
- States: IDLE → LOAD → MAC → WRITE → (MAC | DONE) → IDLE.
- IDLE: `start`=1 moves to LOAD; operands and n=`matrix_size`+2 are latched at this edge.
- Latched operands are re-strided from n×n packing to 5x5 stride; unused positions are zero.
- LOAD: clears `result_out`, `overflow_flag`, accumulator, and indices i,j,k.
- MAC: acc += a[i][k]·b[k][j] (full signed product, sign-extended to ACC_W); k increments; after k=n−1, go to WRITE.
- WRITE: result(i,j) ← acc[7:0]; `overflow_flag` |= (acc>127 or acc<−128); acc←0, k←0; advance j, wrapping to next i at j=n−1.
- After WRITE of (n−1,n−1), go to DONE. Otherwise go to MAC.
- DONE: `done`=1 for one cycle; next state IDLE.
- Elements outside n×n stay zero.
- `result_out`/`overflow_flag` hold after DONE until the next LOAD.
- `start` in any non-IDLE state is ignored; operand/size changes after capture are ignored.
- `start` held high restarts every n²(n+1)+3 cycles.

## Timing
- Reset values: `busy`=0, `done`=0, `result_out`=0, `overflow_flag`=0, state IDLE.
- Edge 0 samples `start`. `done` is high in the cycle after edge n²(n+1)+1.
  - n=2: edge 13; n=3: 37; n=4: 81; n=5: 151.
- `reset` mid-operation: the next edge gives IDLE with all outputs at reset values; the partial result is discarded.
- `reset` and `start` high on the same edge: `reset` wins.
- A new `start` is accepted on the first IDLE cycle after DONE.

## Configuration
- `MULT_SATURATE_EN` defined: WRITE stores clamp(acc) to [−128,127] (0x7F / 0x80); the overflow flag is unchanged.
- `MULT_SATURATE_EN` undefined: WRITE stores acc[7:0] (wrap-around truncation).

## Structure
- Shared package `pacote_matriz`:
  - state encoding;
  - MAT_DIM, ELEM_W, ACC_W;
  - size codes SIZE_2X2..SIZE_5X5;
  - packed-offset helper (i*5+j)*8.
- One sub-module, `mac_elemento`: a registered signed 8x8 multiply-accumulate with clear, used by the controller.

## Test plan
- 2x2, A=[1,2,3,4], B=[5,6,7,8], start at edge 0:
  - `done` high after edge 13;
  - result(0..1,0..1)=[19,22,43,50];
  - other 21 elements 0; overflow 0.
- 5x5, A=identity, B=elements 0..24 (result element e=B e):
  - `done` high after edge 151;
  - result=B; overflow 0.
- 3x3, all elements 127:
  - each sum 48387, overflow 1;
  - elements 0x03 without the macro, 0x7F with it.
- 2x2, A=[−128,0,0,0], B=[−128,0,0,0]:
  - (0,0) sum 16384, overflow 1;
  - stored 0x00 without the macro, 0x7F with it.
- 2x2, A=[−1,2,3,−4], B=identity:
  - result (0,0..1,1)=[0xFF,0x02,0x03,0xFC]; overflow 0.
- Busy-path control:
  - `start` pulsed during MAC with different operands: ignored, original result produced;
  - `reset` asserted at edge 20 of a 5x5 run: all outputs 0, IDLE, no `done`;
  - `start` on the next cycle completes normally.
